// File: rtl/gpio_bus_responder_if.sv
// ============================================================================
// Module : gpio_bus_responder_if
// Brief  : CPU data-bus handshake between the memory stage and the GPIO block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface gpio_bus_responder_if;
    logic [31:0] bus_addr;
    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_addr, bus_wr_en, bus_rd_en, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_wr_en, bus_rd_en, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

`default_nettype wire

// File: rtl/gpio_bus_responder.sv
// ============================================================================
// Module : gpio_bus_responder
// Brief  : Memory-mapped GPIO responder with edge interrupts. Optional per-pin
//          input debounce is enabled by defining GPIO_DEBOUNCE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gpio_bus_responder #(
    parameter int          IO_W        = 20,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
    parameter int          SYNC_STAGES = 2
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    gpio_bus_responder_if.slave  bus,
    input  wire logic [IO_W-1:0] io_in,
    output logic      [IO_W-1:0] io_out,
    output logic      [IO_W-1:0] io_oe,
    output logic                 irq
);

    localparam logic [2:0] c_OFF_DOUT   = 3'd0;
    localparam logic [2:0] c_OFF_DIR    = 3'd1;
    localparam logic [2:0] c_OFF_DIN    = 3'd2;
    localparam logic [2:0] c_OFF_IRQEN  = 3'd3;
    localparam logic [2:0] c_OFF_IRQST  = 3'd4;
    localparam logic [2:0] c_OFF_EDGE   = 3'd5;

    logic [SYNC_STAGES-1:0][IO_W-1:0] r_sync;
    logic [IO_W-1:0] r_dout, r_dir, r_irq_en, r_irq_stat, r_edge_sel, r_prev;
    logic [IO_W-1:0] w_sync, w_din, w_edge, w_w1c;
    logic [31:0]     r_rdata, w_rd_mux;
    logic            r_rvalid, r_irq;
    logic            w_hit, w_wr, w_rd;
    logic [2:0]      w_off;
    logic            w_unused_bits;

    assign w_hit = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr  = w_hit & bus.bus_wr_en;
    assign w_rd  = w_hit & bus.bus_rd_en;
    assign w_off = bus.bus_addr[4:2];
    assign w_unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata};

    // Index 0 is the first flop after the pin; the last stage feeds DIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], io_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int DEBOUNCE_CYC = 1000;

    for (genvar gi = 0; gi < IO_W; gi++) begin : g_debounce
        logic [15:0] r_cnt;
        logic        r_bit;

        // DIN follows the synchronized pin only after it has disagreed for
        // DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (w_sync[gi] != r_bit) begin
                if (r_cnt == 16'(DEBOUNCE_CYC - 1)) begin
                    r_bit <= w_sync[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_din[gi] = r_bit;
    end
`else
    assign w_din = w_sync;
`endif

    assign w_edge = ( r_edge_sel & r_prev & ~w_din)
                  | (~r_edge_sel & ~r_prev & w_din);

    assign w_w1c = (w_wr && (w_off == c_OFF_IRQST)) ? bus.bus_wdata[IO_W-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            c_OFF_DOUT:  w_rd_mux = 32'(r_dout);
            c_OFF_DIR:   w_rd_mux = 32'(r_dir);
            c_OFF_DIN:   w_rd_mux = 32'(w_din);
            c_OFF_IRQEN: w_rd_mux = 32'(r_irq_en);
            c_OFF_IRQST: w_rd_mux = 32'(r_irq_stat);
            c_OFF_EDGE:  w_rd_mux = 32'(r_edge_sel);
            default:     w_rd_mux = '0;
        endcase
    end

    // Status set is OR-ed in after the clear so a coincident edge wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dout     <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_edge_sel <= '0;
            r_prev     <= '0;
            r_irq      <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_prev     <= w_din;
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_edge;
            r_irq      <= |(r_irq_stat & r_irq_en);
            r_rvalid   <= w_rd;
            r_rdata    <= w_rd ? w_rd_mux : 32'd0;
            if (w_wr) begin
                case (w_off)
                    c_OFF_DOUT:  r_dout     <= bus.bus_wdata[IO_W-1:0];
                    c_OFF_DIR:   r_dir      <= bus.bus_wdata[IO_W-1:0];
                    c_OFF_IRQEN: r_irq_en   <= bus.bus_wdata[IO_W-1:0];
                    c_OFF_EDGE:  r_edge_sel <= bus.bus_wdata[IO_W-1:0];
                    default:     ;
                endcase
            end
        end
    end

    assign io_out         = r_dout;
    assign io_oe          = r_dir;
    assign irq            = r_irq;
    assign bus.bus_rdata  = r_rdata;
    assign bus.bus_rvalid = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_gpio_bus_responder.sv
// ============================================================================
// Module : tb_gpio_bus_responder
// Brief  : Directed self-checking bench for gpio_bus_responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_bus_responder;

    localparam logic [31:0] c_BASE = 32'h0000_8000;

    logic        CLK;
    logic        RST;
    logic [19:0] io_in;
    logic [19:0] io_out;
    logic [19:0] io_oe;
    logic        irq;
    int          total;
    int          bad;

    gpio_bus_responder_if bus();

    gpio_bus_responder #(
        .IO_W        (20),
        .BASE_ADDR   (c_BASE),
        .SYNC_STAGES (2)
    ) u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bus.slave),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oe  (io_oe),
        .irq    (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_wr_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d);
        bus.bus_addr  = a;
        bus.bus_rd_en = 1'b1;
        tick();
        bus.bus_rd_en = 1'b0;
        v = bus.bus_rvalid;
        d = bus.bus_rdata;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.bus_addr  = c_BASE;
        bus.bus_rd_en = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.bus_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_drop_rvalid got=%b exp=0", bus.bus_rvalid);
        end
        bus.bus_rd_en = 1'b0;
        RST = 1'b0;
        total++;
        if (io_oe !== 20'h0 || io_out !== 20'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got oe=%h out=%h irq=%b exp 0/0/0", io_oe, io_out, irq);
        end
        // back-to-back reads across the whole window
        bus.bus_rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.bus_addr = c_BASE + 32'(i * 4);
            tick();
            total++;
            if (bus.bus_rvalid !== 1'b1 || bus.bus_rdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_read_%0d got v=%b d=%h exp v=1 d=0", i, bus.bus_rvalid, bus.bus_rdata);
            end
        end
        bus.bus_rd_en = 1'b0;
        tick();
        total++;
        if (bus.bus_rvalid !== 1'b0 || bus.bus_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rvalid_pulse got v=%b d=%h exp v=0 d=0", bus.bus_rvalid, bus.bus_rdata);
        end
    endtask

    task automatic test_drive_dir();
        logic        v;
        logic [31:0] d;
        do_write(c_BASE + 32'h00, 32'h0005_A5A5);
        total++;
        if (io_out !== 20'h5A5A5) begin
            bad++;
            $display("FAIL io_out got=%h exp=5a5a5", io_out);
        end
        do_write(c_BASE + 32'h04, 32'h000F_FFFF);
        total++;
        if (io_oe !== 20'hFFFFF) begin
            bad++;
            $display("FAIL io_oe got=%h exp=fffff", io_oe);
        end
        do_read(c_BASE + 32'h00, v, d);
        total++;
        if (v !== 1'b1 || d !== 32'h0005_A5A5) begin
            bad++;
            $display("FAIL read_dout got v=%b d=%h exp v=1 d=0005a5a5", v, d);
        end
        tick();
        total++;
        if (bus.bus_rvalid !== 1'b0 || bus.bus_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rdata_idle got v=%b d=%h exp v=0 d=0", bus.bus_rvalid, bus.bus_rdata);
        end
        do_write(c_BASE + 32'h04, 32'hFFFF_FFFF);
        do_read(c_BASE + 32'h04, v, d);
        total++;
        if (d !== 32'h000F_FFFF) begin
            bad++;
            $display("FAIL dir_upper_bits got=%h exp=000fffff", d);
        end
        do_write(c_BASE + 32'h1C, 32'hDEAD_BEEF);
        do_read(c_BASE + 32'h1C, v, d);
        total++;
        if (v !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL reserved_reg got v=%b d=%h exp v=1 d=0", v, d);
        end
        do_write(c_BASE + 32'h04, 32'h0);
    endtask

    task automatic test_input_sync();
        logic        v;
        logic [31:0] d;
        logic [31:0] exp_din [3];
        exp_din[0] = 32'h0;
        exp_din[1] = 32'h0;
        exp_din[2] = 32'h3;
        io_in         = 20'h00003;
        bus.bus_addr  = c_BASE + 32'h08;
        bus.bus_rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.bus_rdata !== exp_din[i]) begin
                bad++;
                $display("FAIL din_latency_%0d got=%h exp=%h", i, bus.bus_rdata, exp_din[i]);
            end
        end
        bus.bus_rd_en = 1'b0;
        tick();
        do_read(c_BASE + 32'h10, v, d);
        total++;
        if (d !== 32'h3 || irq !== 1'b0) begin
            bad++;
            $display("FAIL stat_without_en got stat=%h irq=%b exp stat=3 irq=0", d, irq);
        end
    endtask

    task automatic test_rising_irq();
        logic        v;
        logic [31:0] d;
        io_in = 20'h0;
        repeat (4) tick();
        do_write(c_BASE + 32'h10, 32'h000F_FFFF);
        do_write(c_BASE + 32'h0C, 32'h1);
        do_write(c_BASE + 32'h14, 32'h0);
        tick();
        io_in = 20'h00001;
        repeat (3) tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_early got=%b exp=0", irq);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_rise got=%b exp=1", irq);
        end
        do_read(c_BASE + 32'h10, v, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL stat_rise got=%h exp=1", d);
        end
        do_write(c_BASE + 32'h10, 32'h1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_clear_lag got=%b exp=1", irq);
        end
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_cleared got=%b exp=0", irq);
        end
        do_read(c_BASE + 32'h10, v, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL stat_cleared got=%h exp=0", d);
        end
        io_in = 20'h0;
        repeat (6) tick();
        do_read(c_BASE + 32'h10, v, d);
        total++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL falling_ignored got stat=%h irq=%b exp 0/0", d, irq);
        end
    endtask

    task automatic test_collision();
        logic        v;
        logic [31:0] d;
        io_in = 20'h00001;
        tick();
        tick();
        bus.bus_addr  = c_BASE + 32'h10;
        bus.bus_wdata = 32'h1;
        bus.bus_wr_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL collision_irq got=%b exp=1", irq);
        end
        do_read(c_BASE + 32'h10, v, d);
        total++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            bad++;
            $display("FAIL collision_stat got stat=%h irq=%b exp 1/1", d, irq);
        end
    endtask

    task automatic test_same_cycle_and_miss();
        logic        v;
        logic [31:0] d;
        do_write(c_BASE + 32'h00, 32'h11);
        bus.bus_addr  = c_BASE + 32'h00;
        bus.bus_wdata = 32'h0001_2345;
        bus.bus_wr_en = 1'b1;
        bus.bus_rd_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        total++;
        if (bus.bus_rvalid !== 1'b1 || bus.bus_rdata !== 32'h11) begin
            bad++;
            $display("FAIL rw_same_cycle got v=%b d=%h exp v=1 d=11", bus.bus_rvalid, bus.bus_rdata);
        end
        total++;
        if (io_out !== 20'h12345) begin
            bad++;
            $display("FAIL rw_io_out got=%h exp=12345", io_out);
        end
        do_read(c_BASE + 32'h00, v, d);
        total++;
        if (d !== 32'h0001_2345) begin
            bad++;
            $display("FAIL rw_readback got=%h exp=00012345", d);
        end
        bus.bus_addr  = 32'h0000_9000;
        bus.bus_wdata = 32'h000A_BCDE;
        bus.bus_wr_en = 1'b1;
        bus.bus_rd_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        total++;
        if (bus.bus_rvalid !== 1'b0 || io_out !== 20'h12345) begin
            bad++;
            $display("FAIL miss_9000 got v=%b out=%h exp v=0 out=12345", bus.bus_rvalid, io_out);
        end
        do_write(c_BASE + 32'h20, 32'h0);
        do_read(c_BASE + 32'h20, v, d);
        total++;
        if (v !== 1'b0 || io_out !== 20'h12345) begin
            bad++;
            $display("FAIL miss_window_end got v=%b out=%h exp v=0 out=12345", v, io_out);
        end
        do_read(c_BASE + 32'h03, v, d);
        total++;
        if (v !== 1'b1 || d !== 32'h0001_2345) begin
            bad++;
            $display("FAIL low_addr_bits got v=%b d=%h exp v=1 d=00012345", v, d);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        RST           = 1'b1;
        io_in         = 20'h0;
        bus.bus_addr  = 32'h0;
        bus.bus_wdata = 32'h0;
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        test_reset();
        test_drive_dir();
        test_input_sync();
        test_rising_irq();
        test_collision();
        test_same_cycle_and_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_bus_responder.md
Name: gpio_bus_responder

Overview:
- Memory-mapped responder connecting the MIPS data bus to the 20-bit board IO port.
- CPU loads and stores reach pin output, direction, input and interrupt registers.
- The block also raises the CPU Interrupt line on selected input edges.
- Tristate resolution lives in the wrapper: this block exposes split io_out / io_oe / io_in.

Parameters:
- IO_W, 20: number of IO pins (1..32).
- BASE_ADDR, 32'h0000_8000: byte base address of the register window.
- SYNC_STAGES, 2: input synchronizer depth (≥2).

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- bus_addr  input  32  byte address from CPU memory stage
- bus_wr_en  input  1  store strobe, one cycle
- bus_rd_en  input  1  load strobe, one cycle
- bus_wdata  input  32  store data
- bus_rdata  output  32  load data, valid when bus_rvalid=1
- bus_rvalid  output  1  load response strobe
- io_in  input  IO_W  raw asynchronous pin values
- io_out  output  IO_W  pin drive values
- io_oe  output  IO_W  per-pin output enable (1 = drive)
- irq  output  1  level interrupt request to CPU

Behaviour:
- Decode: hit when bus_addr[31:5] == BASE_ADDR[31:5]. Register offset = bus_addr[4:2]; bus_addr[1:0] ignored.
- Register map:
  - 0x00 DOUT, RW.
  - 0x04 DIR, RW (1 = output).
  - 0x08 DIN, RO: synchronized pins.
  - 0x0C IRQ_EN, RW.
  - 0x10 IRQ_STAT, RW1C.
  - 0x14 EDGE_SEL, RW (0 = rising, 1 = falling).
  - 0x18–0x1C: read 0, writes ignored.
- Register width: IO_W bits used; upper bits read 0, write-ignored.
- Reset (RST=1 at posedge): all registers 0, io_out=0, io_oe=0 (all pins input), irq=0, bus_rdata=0, bus_rvalid=0, synchronizer flops 0. Reset asserted mid-transaction drops any pending response (no rvalid).
- Writes take effect at the posedge where bus_wr_en=1. io_out=DOUT and io_oe=DIR are driven directly from the register flops (visible one cycle after the store).
- Reads: one-cycle latency. bus_rd_en=1 at edge N gives bus_rvalid=1 with data during cycle N+1. bus_rvalid is a single-cycle pulse; bus_rdata returns to 0 when bus_rvalid=0. Back-to-back reads are supported every cycle.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- A non-hit access produces no rvalid and no state change.
- Input path: io_in → SYNC_STAGES flop chain → DIN. prev holds DIN from the previous cycle.
- Edge detect: edge[i] = EDGE_SEL[i] ? (prev[i] & ~DIN[i]) : (~prev[i] & DIN[i]).
- Pins with DIR[i]=1 still sample and can flag edges, which allows loopback.
- IRQ_STAT[i] sets on edge[i], regardless of IRQ_EN. Writing 1 clears the bit; writing 0 has no effect.
- Set and W1C clear on the same bit in the same cycle: set wins.
- irq = |(IRQ_STAT & IRQ_EN), registered, so it appears one cycle after the STAT/EN update.
- Latency from pin change to IRQ_STAT set: SYNC_STAGES+1 cycles. Add 1 more cycle for irq.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- When defined:
  - Each pin gets a 16-bit counter after the synchronizer.
  - DIN[i] updates only after the synchronized value differs from DIN[i] for DEBOUNCE_CYC consecutive cycles (localparam, default 1000).
  - The counter resets to 0 whenever the value matches DIN[i] again.
  - Edges are detected on the debounced DIN.
- When undefined: DIN is the raw synchronizer output, and no counters are present.

Test Plan:
- Reset defaults: hold RST 3 cycles, then read all offsets 0x00–0x1C → each rvalid pulse carries 0; io_oe=0, irq=0.
- Drive and direction: write DOUT=0x5A5A5, DIR=0xFFFFF.
  - Next cycle: io_out=0x5A5A5, io_oe=0xFFFFF.
  - Read 0x00 → 0x5A5A5 one cycle after rd_en.
  - Write 0xFFFFFFFF to DIR, read back → 0x000FFFFF.
- Input sync and latency: DIR=0, io_in 0→0x00003 at cycle T → DIN reads 0x00003 from cycle T+2 on (SYNC_STAGES=2).
- Rising-edge interrupt:
  - IRQ_EN=0x00001, EDGE_SEL=0, io_in[0] 0→1 → IRQ_STAT=0x1 at T+3, irq=1 at T+4.
  - Write 0x1 to 0x10 → IRQ_STAT=0, irq=0 one cycle later.
  - Falling edge on pin 0 sets nothing.
- Clear/set collision: W1C of bit 0 in the same cycle an edge on bit 0 is detected → IRQ_STAT[0] stays 1, irq stays 1.
- Same-cycle read/write and miss: read+write DOUT 0x12345 while DOUT=0x00011 → rdata 0x00011, later read 0x12345. Access address 0x0000_9000 → no rvalid, registers unchanged.
